// File: rtl/sram_req_ctrl.sv
// Initiator-side controller for a 1RW SRAM port: registers client requests onto the SRAM
// pins, tracks fixed read latency and returns read data in order through a credit-protected FIFO.
module sram_req_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MASK_W    = 4,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [MASK_W-1:0] req_wmask_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              sram_cs_o,
    output logic              sram_we_o,
    output logic [MASK_W-1:0] sram_wmask_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wr_data_o,
    input  logic [DATA_W-1:0] sram_rd_data_i,
    output logic              busy_o
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              accept;
    logic              iss_read;
    logic [RD_LAT-1:0] rd_pipe;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];
    logic [31:0]       credit_used;

    assign accept   = req_valid_i & req_ready_o;
    assign iss_read = sram_cs_o & ~sram_we_o;
    assign push     = rd_pipe[RD_LAT-1];
    assign pop      = rsp_valid_o & rsp_ready_i;

    // Every read that may still need a FIFO slot holds a credit, so a push can never overflow.
    // NOTE: always_comb accumulates with blocking '=' so each loop step sees the previous sum;
    // state registers below use '<=' so all flops update together at the edge.
    always_comb begin
        credit_used = 32'(iss_read) + 32'(fifo_count);
        for (int i = 0; i < RD_LAT; i++) begin
            credit_used = credit_used + 32'(rd_pipe[i]);
        end
    end

    assign req_ready_o = !rst && (credit_used < 32'(RSP_DEPTH));

    // Issue stage: one registered SRAM access per accepted request; addr/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_cs_o      <= 1'b0;
            sram_we_o      <= 1'b0;
            sram_wmask_o   <= '0;
            sram_addr_o    <= '0;
            sram_wr_data_o <= '0;
        end else if (accept) begin
            sram_cs_o      <= 1'b1;
            sram_we_o      <= req_we_i;
            sram_wmask_o   <= req_we_i ? req_wmask_i : '0;
            sram_addr_o    <= req_addr_i;
            sram_wr_data_o <= req_wdata_i;
        end else begin
            sram_cs_o      <= 1'b0;
            sram_we_o      <= 1'b0;
            sram_wmask_o   <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= iss_read;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is tracked by the
    // pointers/count, and the output mux below hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_rd_data_i;
        end
    end

    assign rsp_valid_o = (fifo_count != '0);
    assign rsp_rdata_o = rsp_valid_o ? fifo_mem[rd_ptr] : '0;
    assign busy_o      = sram_cs_o | (|rd_pipe) | rsp_valid_o;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed testbench for sram_req_ctrl with a behavioural 1RW SRAM (read latency 1).
module tb_sram_req_ctrl;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int MASK_W    = 4;
    localparam int RD_LAT    = 1;
    localparam int RSP_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready_o;
    logic              req_we;
    logic [MASK_W-1:0] req_wmask;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid_o;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              sram_cs_o;
    logic              sram_we_o;
    logic [MASK_W-1:0] sram_wmask_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_wr_data_o;
    logic [DATA_W-1:0] sram_rd_data;
    logic              busy_o;

    logic [DATA_W-1:0] sram_mem [256];
    logic [DATA_W-1:0] sram_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_req_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
        .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we),
        .req_wmask_i    (req_wmask),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready),
        .rsp_rdata_o    (rsp_rdata_o),
        .sram_cs_o      (sram_cs_o),
        .sram_we_o      (sram_we_o),
        .sram_wmask_o   (sram_wmask_o),
        .sram_addr_o    (sram_addr_o),
        .sram_wr_data_o (sram_wr_data_o),
        .sram_rd_data_i (sram_rd_data),
        .busy_o         (busy_o)
    );

    // SRAM model: byte-masked write, read data valid one cycle after the sampling edge.
    always @(posedge clk) begin
        if (sram_cs_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < MASK_W; b++) begin
                    if (sram_wmask_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wr_data_o[8*b +: 8];
                end
            end else begin
                sram_q <= sram_mem[sram_addr_o];
            end
        end
    end
    assign sram_rd_data = sram_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wmask = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                              input logic [MASK_W-1:0] mask);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_wmask = mask;
        tick();
        idle_inputs();
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] addr);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        req_wdata = '0;
        req_wmask = '0;
        tick();
        idle_inputs();
    endtask

    task automatic drain(input string name);
        rsp_ready = 1'b1;
        for (int n = 0; n < 20 && busy_o !== 1'b0; n++) tick();
        rsp_ready = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_drain: busy_o=%b required 0", name, busy_o);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++;
        if (req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: req_ready_o=%b required 0", req_ready_o);
        end
        checks++;
        if ({sram_cs_o, sram_we_o, sram_wmask_o, sram_addr_o, sram_wr_data_o} !== '0) begin
            failures++;
            $display("FAIL reset_sram_pins: cs=%b we=%b mask=%h addr=%h wdata=%h required all 0",
                     sram_cs_o, sram_we_o, sram_wmask_o, sram_addr_o, sram_wr_data_o);
        end
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== '0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp: valid=%b rdata=%h busy=%b required 0/0/0",
                     rsp_valid_o, rsp_rdata_o, busy_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: req_ready_o=%b required 1", req_ready_o);
        end
    endtask

    task automatic test_write_read();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h10;
        req_wdata = 32'hDEAD_BEEF;
        req_wmask = 4'hF;
        tick();
        checks++;
        if (sram_cs_o !== 1'b1 || sram_we_o !== 1'b1 || sram_wmask_o !== 4'hF ||
            sram_addr_o !== 8'h10 || sram_wr_data_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_issue: cs=%b we=%b mask=%h addr=%h wdata=%h required 1/1/f/10/deadbeef",
                     sram_cs_o, sram_we_o, sram_wmask_o, sram_addr_o, sram_wr_data_o);
        end
        req_we    = 1'b0;
        req_wdata = '0;
        req_wmask = 4'hF;
        tick();
        checks++;
        if (sram_cs_o !== 1'b1 || sram_we_o !== 1'b0 || sram_wmask_o !== 4'h0 ||
            sram_addr_o !== 8'h10) begin
            failures++;
            $display("FAIL rd_issue: cs=%b we=%b mask=%h addr=%h required 1/0/0/10",
                     sram_cs_o, sram_we_o, sram_wmask_o, sram_addr_o);
        end
        idle_inputs();
        tick();
        checks++;
        if (sram_cs_o !== 1'b0 || sram_we_o !== 1'b0 || sram_wmask_o !== 4'h0 ||
            sram_addr_o !== 8'h10 || rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_pins: cs=%b we=%b mask=%h addr=%h rsp_valid=%b required 0/0/0/10/0",
                     sram_cs_o, sram_we_o, sram_wmask_o, sram_addr_o, rsp_valid_o);
        end
        tick();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL rd_latency_data: valid=%b rdata=%h required 1/deadbeef",
                     rsp_valid_o, rsp_rdata_o);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rd_pop: valid=%b busy=%b required 0/0", rsp_valid_o, busy_o);
        end
    endtask

    task automatic test_masked_write();
        write_word(8'h20, 32'h1122_3344, 4'hF);
        write_word(8'h20, 32'hAABB_CCDD, 4'h5);
        read_word(8'h20);
        for (int n = 0; n < 10 && rsp_valid_o !== 1'b1; n++) tick();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h11BB_33DD) begin
            failures++;
            $display("FAIL masked_write: valid=%b rdata=%h required 1/11bb33dd", rsp_valid_o, rsp_rdata_o);
        end
        drain("masked");
    endtask

    task automatic test_stream();
        int   issued = 0;
        int   got    = 0;
        int   first  = -1;
        int   last   = -1;
        int   ready_drops = 0;
        logic acc;
        for (int i = 0; i < 16; i++) write_word(ADDR_W'(i), DATA_W'(i * 3), 4'hF);
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            if (rsp_valid_o === 1'b1) begin
                checks++;
                if (rsp_rdata_o !== DATA_W'(got * 3)) begin
                    failures++;
                    $display("FAIL stream_data[%0d]: rdata=%h required %h", got, rsp_rdata_o, DATA_W'(got * 3));
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (issued < 16) begin
                req_valid = 1'b1;
                req_we    = 1'b0;
                req_addr  = ADDR_W'(issued);
                if (req_ready_o !== 1'b1) ready_drops++;
            end else begin
                idle_inputs();
            end
            acc = req_valid & req_ready_o;
            tick();
            if (acc) issued++;
        end
        idle_inputs();
        rsp_ready = 1'b0;
        checks++;
        if (ready_drops != 0) begin
            failures++;
            $display("FAIL stream_ready: ready low in %0d issue cycles required 0", ready_drops);
        end
        checks++;
        if (got != 16 || last - first != 15) begin
            failures++;
            $display("FAIL stream_count: got=%0d span=%0d required 16/15", got, last - first);
        end
        drain("stream");
    endtask

    task automatic test_backpressure();
        int   accepted = 0;
        int   got      = 0;
        logic acc;
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = ADDR_W'(4 + accepted);
            acc = req_ready_o;
            tick();
            if (acc) accepted++;
        end
        idle_inputs();
        checks++;
        if (accepted != RSP_DEPTH || req_ready_o !== 1'b0 || rsp_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall: accepted=%0d ready=%b valid=%b required %0d/0/1",
                     accepted, req_ready_o, rsp_valid_o, RSP_DEPTH);
        end
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (rsp_valid_o === 1'b1) begin
                checks++;
                if (rsp_rdata_o !== DATA_W'((4 + got) * 3)) begin
                    failures++;
                    $display("FAIL bp_data[%0d]: rdata=%h required %h", got, rsp_rdata_o, DATA_W'((4 + got) * 3));
                end
                got++;
            end
            tick();
        end
        rsp_ready = 1'b0;
        checks++;
        if (got != RSP_DEPTH || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL bp_resume: got=%0d valid=%b ready=%b required %0d/0/1",
                     got, rsp_valid_o, req_ready_o, RSP_DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'd1;
        tick();
        req_addr  = 8'd2;
        tick();
        req_addr  = 8'd3;
        tick();
        idle_inputs();
        checks++;
        if (rsp_valid_o !== 1'b1 || sram_cs_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_setup: valid=%b cs=%b required 1/1", rsp_valid_o, sram_cs_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_ready: req_ready_o=%b required 0", req_ready_o);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0 || sram_cs_o !== 1'b0 || busy_o !== 1'b0 || rsp_rdata_o !== '0) begin
            failures++;
            $display("FAIL rstmid_clear: valid=%b cs=%b busy=%b rdata=%h required 0/0/0/0",
                     rsp_valid_o, sram_cs_o, busy_o, rsp_rdata_o);
        end
        rsp_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (rsp_valid_o !== 1'b0) stale++;
            tick();
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL rstmid_stale: %0d stale response cycles required 0", stale);
        end
        rsp_ready = 1'b0;
        read_word(8'd9);
        for (int n = 0; n < 10 && rsp_valid_o !== 1'b1; n++) tick();
        checks++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'd27) begin
            failures++;
            $display("FAIL rstmid_read: valid=%b rdata=%h required 1/0000001b", rsp_valid_o, rsp_rdata_o);
        end
        drain("rstmid");
    endtask

    task automatic test_push_pop();
        logic [DATA_W-1:0] exp_q [3];
        exp_q[0] = 32'd6;
        exp_q[1] = 32'd9;
        exp_q[2] = 32'd15;
        rsp_ready = 1'b0;
        read_word(8'd1);
        read_word(8'd2);
        read_word(8'd3);
        tick();
        tick();
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'd3) begin
            failures++;
            $display("FAIL pp_fill3: ready=%b valid=%b rdata=%h required 1/1/3",
                     req_ready_o, rsp_valid_o, rsp_rdata_o);
        end
        read_word(8'd5);
        tick();
        checks++;
        if (req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL pp_credit_full: req_ready_o=%b required 0", req_ready_o);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'd6) begin
            failures++;
            $display("FAIL pp_same_cycle: ready=%b valid=%b rdata=%h required 1/1/6",
                     req_ready_o, rsp_valid_o, rsp_rdata_o);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_q[k]) begin
                failures++;
                $display("FAIL pp_order[%0d]: valid=%b rdata=%h required 1/%h",
                         k, rsp_valid_o, rsp_rdata_o, exp_q[k]);
            end
            tick();
        end
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL pp_empty: valid=%b required 0", rsp_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_push_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
